// File: rtl/ahb_modport.sv
// AHB-Lite slave memory: pipelined address/data phases, optional wait states and byte-lane writes.
// Define AHB_MODPORT_ERR_EN to enable the two-cycle ERROR response for bad addresses and sizes.
module ahb_modport #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic              write_q, write_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BYTES-1:0]  be_q, be_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              accept;
    logic [OFF_W-1:0]  off_a;
    logic [IDX_W-1:0]  idx_a;
    logic [2:0]        size_eff;
    logic [BYTES-1:0]  be_a;
    logic              err_a;
    logic              complete;
    logic              commit;
    logic [DATA_W-1:0] rd_fwd;
    logic              unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HTRANS[0], HADDR};

    assign accept   = HSEL && HTRANS[1] && HREADY;
    assign off_a    = HADDR[OFF_W-1:0];
    assign idx_a    = HADDR[OFF_W +: IDX_W];
    assign size_eff = (HSIZE > 3'(OFF_W)) ? 3'(OFF_W) : HSIZE;

    // A lane is enabled when it sits in the same size-aligned block as the address.
    always_comb begin
        be_a = '0;
        for (int k = 0; k < BYTES; k++) begin
            be_a[k] = (k >> size_eff) == (int'(off_a) >> size_eff);
        end
    end

`ifdef AHB_MODPORT_ERR_EN
    always_comb begin
        err_a = (HSIZE > 3'(OFF_W)) || ((HADDR >> (OFF_W + IDX_W)) != '0);
        for (int i = 0; i < OFF_W; i++) begin
            if ((i < int'(size_eff)) && off_a[i]) begin
                err_a = 1'b1;
            end
        end
    end
`else
    assign err_a = 1'b0;
`endif

    assign complete = (state_q == ST_IDLE) && pend_q;
    assign commit   = complete && write_q;

    // The read of a new address phase coincides with the commit of the previous write.
    always_comb begin
        rd_fwd = mem[idx_a];
        if (commit && (idx_q == idx_a)) begin
            for (int k = 0; k < BYTES; k++) begin
                if (be_q[k]) begin
                    rd_fwd[8*k +: 8] = HWDATA[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d = state_q;
        pend_d  = pend_q;
        write_d = write_q;
        idx_d   = idx_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                pend_d  = 1'b0;
                state_d = ST_IDLE;
                if (accept) begin
                    write_d = HWRITE;
                    idx_d   = idx_a;
                    be_d    = be_a;
                    rdata_d = rd_fwd;
                    if (err_a) begin
                        state_d = ST_ERR1;
                    end else begin
                        pend_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = ST_WAIT;
                            cnt_d   = 4'(WAIT_STATES);
                        end
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the array has no reset; contents must survive HRESET and a reset would block RAM mapping.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int k = 0; k < BYTES; k++) begin
                if (be_q[k]) begin
                    mem[idx_q][8*k +: 8] <= HWDATA[8*k +: 8];
                end
            end
        end
    end

    assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign HRDATA    = (complete && !write_q) ? rdata_q : '0;

`ifdef AHB_MODPORT_ERR_EN
    assign HRESP = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
    assign HRESP = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_modport.sv
// Bench for ahb_modport: a zero-wait and a two-wait instance, checked against a byte-array model.
module tb_ahb_modport;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel_v;
    logic        cur;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hsel0, hsel2;
    logic        ro0, ro2, resp0, resp2;
    logic [31:0] rd0, rd2;
    logic        ro, rresp;
    logic [31:0] rdat;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign hsel0 = sel_v && !cur;
    assign hsel2 = sel_v && cur;
    assign ro    = cur ? ro2 : ro0;
    assign rresp = cur ? resp2 : resp0;
    assign rdat  = cur ? rd2 : rd0;

    ahb_modport #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(ro0), .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rd0)
    );

    ahb_modport #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) dut2 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(ro2), .HREADYOUT(ro2), .HRESP(resp2), .HRDATA(rd2)
    );

    // Reference memory: one little-endian byte array per instance, 4 KiB each.
    logic [7:0] mm [2][4096];

    logic        pd_valid = 1'b0;
    logic        pd_write = 1'b0;
    logic [31:0] pd_addr  = '0;
    logic [2:0]  pd_size  = '0;
    logic [31:0] pd_wdata = '0;
    logic        pd_err   = 1'b0;
    logic [31:0] pd_exp   = '0;
    string       pd_name  = "start";

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] addr, input logic [2:0] size);
`ifdef AHB_MODPORT_ERR_EN
        return (addr >= 32'h1000) || (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
        int base;
        base = int'((addr % 4096) & ~32'd3);
        return {mm[d][base+3], mm[d][base+2], mm[d][base+1], mm[d][base]};
    endfunction

    task automatic model_write(input int d, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata);
        int n, first, base, lane;
        n     = (size > 3'd2) ? 4 : (1 << size);
        first = int'(addr % 4);
        first = first - (first % n);
        base  = int'((addr % 4096) & ~32'd3);
        for (int j = 0; j < n; j++) begin
            lane = first + j;
            mm[d][base+lane] = wdata[8*lane +: 8];
        end
    endtask

    // Presents one address phase, finishes the previous data phase and checks it.
    task automatic slot(input logic sel, input logic [1:0] trans, input logic write,
                        input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata,
                        input logic use_tbl, input logic [31:0] tbl_exp, input logic tbl_err,
                        input string name);
        int   lows;
        logic done;
        sel_v  = sel;
        htrans = trans;
        hwrite = write;
        haddr  = addr;
        hsize  = size;
        hburst = 3'($urandom_range(0, 7));
        hprot  = 4'($urandom_range(0, 15));
        hwdata = pd_wdata;
        lows   = 0;
        done   = 1'b0;
        for (int c = 0; c < 32 && !done; c++) begin
            @(negedge clk);
            if (ro) begin
                done = 1'b1;
            end else begin
                lows++;
                if (pd_valid) check({pd_name, "_wait_resp"}, 32'(rresp), 32'(pd_err));
                @(posedge clk);
                #1;
            end
        end
        if (!done) check({pd_name, "_ready"}, 32'(ro), 32'd1);
        check({pd_name, "_waits"}, 32'(lows),
              !pd_valid ? 32'd0 : (pd_err ? 32'd1 : (cur ? 32'd2 : 32'd0)));
        check({pd_name, "_resp"}, 32'(rresp), 32'(pd_valid && pd_err));
        check({pd_name, "_rdata"}, rdat,
              (pd_valid && !pd_write && !pd_err) ? pd_exp : 32'd0);
        @(posedge clk);
        #1;
        if (pd_valid && pd_write && !pd_err) model_write(int'(cur), pd_addr, pd_size, pd_wdata);
        pd_valid = sel && trans[1];
        pd_write = write;
        pd_addr  = addr;
        pd_size  = size;
        pd_wdata = wdata;
        pd_err   = use_tbl ? tbl_err : model_err(addr, size);
        pd_exp   = use_tbl ? tbl_exp : model_read(int'(cur), addr);
        pd_name  = name;
    endtask

    task automatic idle_slot(input string name);
        slot(1'b0, 2'd0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b1, 32'h0, 1'b0, name);
    endtask

    function automatic vec_t v(input logic sel, input logic [1:0] trans, input logic write,
                               input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata, input logic [31:0] exp, input logic err);
        vec_t r;
        r = '{sel, trans, write, addr, size, wdata, exp, err};
        return r;
    endfunction

    task automatic rand_ops(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a, hi;
            logic [2:0]  sz;
            hi = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_F000) : 32'h0;
            a  = hi | 32'($urandom_range(0, 255));
            sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            slot($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 a, sz, $urandom, 1'b0, 32'h0, 1'b0, $sformatf("%s%0d", tag, i));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        sel_v  = 1'b0;
        cur    = 1'b0;
        haddr  = '0;
        htrans = 2'd0;
        hwrite = 1'b0;
        hsize  = 3'd2;
        hburst = 3'd0;
        hprot  = 4'd0;
        hwdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", 32'(ro0), 32'd1);
        check("rst_resp0", 32'(resp0), 32'd0);
        check("rst_rdata0", rd0, 32'd0);
        check("rst_ready2", 32'(ro2), 32'd1);
        check("rst_resp2", 32'(resp2), 32'd0);
        check("rst_rdata2", rd2, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill words 0..63 of both instances with a known pattern.
        for (int d = 0; d < 2; d++) begin
            cur = 1'(d);
            for (int i = 0; i < 64; i++) begin
                slot(1'b1, 2'd2, 1'b1, 32'(i * 4), 3'd2, 32'hA5A5_0000 + 32'(i),
                     1'b0, 32'h0, 1'b0, $sformatf("init%0d_%0d", d, i));
            end
            idle_slot("init_flush");
        end

        cur = 1'b0;
        vecs.push_back(v(1, 2'd2, 1, 32'h10, 3'd2, 32'hDEAD_BEEF, 32'h0, 0));
        vecs.push_back(v(1, 2'd2, 0, 32'h10, 3'd2, 32'h0, 32'hDEAD_BEEF, 0));
        vecs.push_back(v(1, 2'd2, 1, 32'h10, 3'd2, 32'h1122_3344, 32'h0, 0));
        vecs.push_back(v(1, 2'd3, 1, 32'h13, 3'd0, 32'hAA00_0000, 32'h0, 0));
        vecs.push_back(v(1, 2'd2, 0, 32'h10, 3'd2, 32'h0, 32'hAA22_3344, 0));
        vecs.push_back(v(1, 2'd0, 1, 32'h10, 3'd2, 32'hFFFF_FFFF, 32'h0, 0));
        vecs.push_back(v(1, 2'd1, 1, 32'h10, 3'd2, 32'hFFFF_FFFF, 32'h0, 0));
        vecs.push_back(v(0, 2'd2, 1, 32'h10, 3'd2, 32'hFFFF_FFFF, 32'h0, 0));
        vecs.push_back(v(1, 2'd2, 0, 32'h10, 3'd2, 32'h0, 32'hAA22_3344, 0));
        vecs.push_back(v(1, 2'd2, 1, 32'h12, 3'd1, 32'h5566_0000, 32'h0, 0));
        vecs.push_back(v(1, 2'd2, 0, 32'h10, 3'd2, 32'h0, 32'h5566_3344, 0));
`ifdef AHB_MODPORT_ERR_EN
        vecs.push_back(v(1, 2'd2, 0, 32'h1000, 3'd2, 32'h0, 32'h0, 1));
        vecs.push_back(v(1, 2'd2, 1, 32'h01, 3'd1, 32'h1234_BEEF, 32'h0, 1));
        vecs.push_back(v(1, 2'd2, 0, 32'h00, 3'd2, 32'h0, 32'hA5A5_0000, 0));
        vecs.push_back(v(1, 2'd2, 0, 32'h04, 3'd3, 32'h0, 32'h0, 1));
        vecs.push_back(v(1, 2'd2, 0, 32'h04, 3'd2, 32'h0, 32'hA5A5_0001, 0));
`else
        vecs.push_back(v(1, 2'd2, 0, 32'h1010, 3'd2, 32'h0, 32'h5566_3344, 0));
        vecs.push_back(v(1, 2'd2, 1, 32'h01, 3'd1, 32'h1234_BEEF, 32'h0, 0));
        vecs.push_back(v(1, 2'd2, 0, 32'h00, 3'd2, 32'h0, 32'hA5A5_BEEF, 0));
        vecs.push_back(v(1, 2'd2, 1, 32'h04, 3'd3, 32'hCAFE_F00D, 32'h0, 0));
        vecs.push_back(v(1, 2'd2, 0, 32'h04, 3'd2, 32'h0, 32'hCAFE_F00D, 0));
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            slot(vecs[i].sel, vecs[i].trans, vecs[i].write, vecs[i].addr, vecs[i].size,
                 vecs[i].wdata, 1'b1, vecs[i].exp, vecs[i].err, $sformatf("vec%0d", i));
        end
        idle_slot("vec_flush");

        // Two-wait instance: plain read, then (when enabled) an error with no leading waits.
        cur = 1'b1;
        slot(1'b1, 2'd2, 1'b0, 32'h20, 3'd2, 32'h0, 1'b1, 32'hA5A5_0008, 1'b0, "w2_read");
`ifdef AHB_MODPORT_ERR_EN
        slot(1'b1, 2'd2, 1'b0, 32'h2000, 3'd2, 32'h0, 1'b1, 32'h0, 1'b1, "w2_err");
`endif
        idle_slot("w2_flush");

        // Reset during the wait states of a write: outputs clear at once, write is dropped.
        sel_v  = 1'b1;
        htrans = 2'd2;
        hwrite = 1'b1;
        haddr  = 32'h24;
        hsize  = 3'd2;
        @(posedge clk);
        #1;
        sel_v  = 1'b0;
        htrans = 2'd0;
        hwdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("rstw_wait_low", 32'(ro2), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rstw_ready", 32'(ro2), 32'd1);
        check("rstw_resp", 32'(resp2), 32'd0);
        check("rstw_rdata", rd2, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        pd_valid = 1'b0;
        pd_wdata = '0;
        pd_name  = "after_rstw";
        slot(1'b1, 2'd2, 1'b0, 32'h24, 3'd2, 32'h0, 1'b1, 32'hA5A5_0009, 1'b0, "rstw_readback");
        idle_slot("rstw_flush");

        // Reset in the completing cycle of a zero-wait read.
        cur = 1'b0;
        slot(1'b1, 2'd2, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'h0, 1'b0, "rstr_read");
        sel_v  = 1'b0;
        htrans = 2'd0;
        @(negedge clk);
        check("rstr_rdata_before", rd0, pd_exp);
        rst = 1'b1;
        #1;
        check("rstr_ready", 32'(ro0), 32'd1);
        check("rstr_resp", 32'(resp0), 32'd0);
        check("rstr_rdata", rd0, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        pd_valid = 1'b0;
        pd_name  = "after_rstr";

        rand_ops(300, "rnd0_");
        idle_slot("rnd0_flush");
        cur = 1'b1;
        rand_ops(120, "rnd2_");
        idle_slot("rnd2_flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
